// File: rtl/key_pkg.sv
// Shared constants for the key debounce / LED bank.
package key_pkg;

  // Debounce counts: 20 ms at 50 MHz for hardware, a short count for simulation
  localparam int CNT_MAX_50MHZ = 999_999;
  localparam int CNT_MAX_SIM   = 7;

  // Per-channel LED behaviour selected by the mode input
  typedef enum logic {
    MODE_FOLLOW = 1'b0,
    MODE_TOGGLE = 1'b1
  } led_mode_e;

endpackage

// File: rtl/key_filter.sv
// One key/LED channel: polarity correction, 2-flop synchroniser, stability
// counter debounce, press pulse and LED register (follow or toggle).
module key_filter
  import key_pkg::*;
#(
  parameter int CNT_MAX    = CNT_MAX_SIM,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  input  logic mode,
  output logic key_state,
  output logic key_flag,
  output logic led_out
);

  // A zero count still needs a one-bit counter to keep the widths legal
  localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             pressed;
  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // 1 means pressed regardless of board wiring
  assign pressed = key_in ^ ACTIVE_LOW;

  // Stage p0/p1: two-flop synchroniser for the asynchronous key level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pressed;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level only after CNT_MAX+1 consecutive differing samples
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt       <= '0;
      key_state <= 1'b0;
      key_flag  <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      if (sync_p1 == key_state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_state <= sync_p1;
        cnt       <= '0;
        // Pulse only on release-to-press; releases update the level silently
        key_flag  <= sync_p1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // LED: follow the debounced level, or flip on every debounced press
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_out <= 1'b0;
    end else if (mode == MODE_TOGGLE) begin
      led_out <= led_out ^ key_flag;
    end else begin
      led_out <= key_state;
    end
  end

endmodule

// File: rtl/key_led_bank.sv
// Bank of CH independent key debounce / LED channels.
module key_led_bank
  import key_pkg::*;
#(
  parameter int CH         = 4,
  parameter int CNT_MAX    = CNT_MAX_50MHZ,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [CH-1:0] key_in,
  input  logic [CH-1:0] mode,
  output logic [CH-1:0] key_state,
  output logic [CH-1:0] key_flag,
  output logic [CH-1:0] led_out
);

  // One filter per channel; channels share nothing but clock and reset
  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_filter #(
      .CNT_MAX   (CNT_MAX),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_filter (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_in   (key_in[i]),
      .mode     (mode[i]),
      .key_state(key_state[i]),
      .key_flag (key_flag[i]),
      .led_out  (led_out[i])
    );
  end

endmodule
